// File: rtl/mem_pkg.sv
// Shared widths, bundle layouts and state encoding for the memory stage.
package mem_pkg;

    localparam int unsigned N   = 24;
    localparam int unsigned BW  = 16 + 2 * N;
    localparam int unsigned WBW = 12 + 2 * N;

    // EX/MEM bundle bit offsets (LSB of each field)
    localparam int unsigned ExOpTypeLsb   = 62;
    localparam int unsigned ExOpCodeLsb   = 58;
    localparam int unsigned ExAluLsb      = 34;
    localparam int unsigned ExZeroBit     = 33;
    localparam int unsigned ExNegBit      = 32;
    localparam int unsigned ExBranchBit   = 31;
    localparam int unsigned ExMemWriteBit = 30;
    localparam int unsigned ExMemToRegBit = 29;
    localparam int unsigned ExRegWriteBit = 28;
    localparam int unsigned ExRcLsb       = 24;
    localparam int unsigned ExRd3Lsb      = 0;

    // MEM/WB bundle bit offsets (LSB of each field)
    localparam int unsigned WbOpTypeLsb   = 58;
    localparam int unsigned WbOpCodeLsb   = 54;
    localparam int unsigned WbAluLsb      = 30;
    localparam int unsigned WbRdataLsb    = 6;
    localparam int unsigned WbMemToRegBit = 5;
    localparam int unsigned WbRegWriteBit = 4;
    localparam int unsigned WbRcLsb       = 0;

    typedef struct packed {
        logic [1:0]   op_type;
        logic [3:0]   op_code;
        logic [N-1:0] alu_result;
        logic         zero;
        logic         neg;
        logic         branch_flag;
        logic         mem_write;
        logic         mem_to_reg;
        logic         reg_write;
        logic [3:0]   rc;
        logic [N-1:0] rd3;
    } ex_mem_t;

    typedef struct packed {
        logic [1:0]   op_type;
        logic [3:0]   op_code;
        logic [N-1:0] alu_result;
        logic [N-1:0] read_data;
        logic         mem_to_reg;
        logic         reg_write;
        logic [3:0]   rc;
    } mem_wb_t;

    typedef enum logic {IDLE, BUSY} mem_state_e;

    localparam mem_wb_t MemWbBubble = '0;

endpackage

// File: rtl/dmem_port_ctrl.sv
// Data-memory handshake FSM: issues one request per instruction and stalls until ack.
// Optional wait limit enabled by defining MEM_TIMEOUT_EN.
module dmem_port_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_op,
    input  logic         is_store,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] wdata,
    input  logic         ack,
    output logic         req,
    output logic         we,
    output logic [N-1:0] req_addr,
    output logic [N-1:0] req_wdata,
    output logic         stall,
    output logic         done,
    output logic         timeout
);

    mem_state_e state_q, state_d;
    logic       req_c, stall_c, done_c, timeout_c;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] TmoMax = CntW'(TIMEOUT);
    logic [CntW-1:0] cnt_q;

    // Counts stall cycles of the current access, including the issuing cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (stall_c) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT;
`endif

    always_comb begin
        state_d   = state_q;
        req_c     = 1'b0;
        stall_c   = 1'b0;
        done_c    = 1'b0;
        timeout_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    req_c = 1'b1;
                    if (ack) begin
                        done_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
`ifdef MEM_TIMEOUT_EN
                if (cnt_q == TmoMax) begin
                    timeout_c = 1'b1;
                    done_c    = 1'b1;
                    state_d   = IDLE;
                end else
`endif
                begin
                    req_c = 1'b1;
                    if (ack) begin
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stall_c = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reset kills the handshake combinationally so the request drops mid-cycle.
    assign req       = req_c & rst;
    assign we        = req_c & rst & is_store;
    assign stall     = stall_c & rst;
    assign done      = done_c & rst;
    assign timeout   = timeout_c & rst;
    assign req_addr  = addr;
    assign req_wdata = wdata;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: unpacks EX/MEM, runs the data-memory access and registers MEM/WB.
// Define MEM_TIMEOUT_EN to bound the wait for dmemAck.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [BW-1:0]  exMemIn,
    output logic           dmemReq,
    output logic           dmemWe,
    output logic [N-1:0]   dmemAddr,
    output logic [N-1:0]   dmemWdata,
    input  logic           dmemAck,
    input  logic [N-1:0]   dmemRdata,
    output logic           stallOut,
    output logic [WBW-1:0] memWbOut,
    output logic [3:0]     fwdRc,
    output logic           fwdRegWrite,
    output logic [15:0]    waitCount,
    output logic           memErr
);

    ex_mem_t ex;
    mem_wb_t mem_wb_q, mem_wb_d;
    logic    mem_op, is_load, stall, done, timeout;
    logic    unused_flags;
    logic [15:0] wait_cnt_q;

    assign ex           = ex_mem_t'(exMemIn);
    assign unused_flags = ^{ex.zero, ex.neg, ex.branch_flag};
    assign mem_op       = ex.mem_write | ex.mem_to_reg;
    // A bundle with both memWrite and memToReg is treated as a store.
    assign is_load      = ex.mem_to_reg & ~ex.mem_write;

    dmem_port_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .mem_op    (mem_op),
        .is_store  (ex.mem_write),
        .addr      (ex.alu_result),
        .wdata     (ex.rd3),
        .ack       (dmemAck),
        .req       (dmemReq),
        .we        (dmemWe),
        .req_addr  (dmemAddr),
        .req_wdata (dmemWdata),
        .stall     (stall),
        .done      (done),
        .timeout   (timeout)
    );

    always_comb begin
        mem_wb_d = MemWbBubble;
        if (!stall) begin
            mem_wb_d.op_type    = ex.op_type;
            mem_wb_d.op_code    = ex.op_code;
            mem_wb_d.alu_result = ex.alu_result;
            mem_wb_d.read_data  = (is_load && done && !timeout) ? dmemRdata : '0;
            mem_wb_d.mem_to_reg = ex.mem_to_reg;
            mem_wb_d.reg_write  = ex.reg_write & ~timeout;
            mem_wb_d.rc         = ex.rc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wb_q   <= MemWbBubble;
            wait_cnt_q <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
            if (stall && wait_cnt_q != 16'hFFFF) begin
                wait_cnt_q <= wait_cnt_q + 16'd1;
            end
        end
    end

    assign memWbOut    = mem_wb_q;
    assign stallOut    = stall;
    assign waitCount   = wait_cnt_q;
    assign memErr      = timeout;
    assign fwdRc       = ex.rc;
    // Load results are only forwardable once the data is on dmemRdata.
    assign fwdRegWrite = ex.reg_write & (~ex.mem_to_reg | dmemAck);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a queue-based scoreboard on memWbOut.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] exMemIn;
    logic        dmemReq, dmemWe, dmemAck;
    logic [23:0] dmemAddr, dmemWdata, dmemRdata;
    logic        stallOut, fwdRegWrite, memErr;
    logic [59:0] memWbOut;
    logic [3:0]  fwdRc;
    logic [15:0] waitCount;

    int compared   = 0;
    int mismatched = 0;
    int req_cycles = 0;
    int stall_cycles = 0;
    logic [59:0] sb_q[$];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk         (clk),
        .rst         (rst),
        .exMemIn     (exMemIn),
        .dmemReq     (dmemReq),
        .dmemWe      (dmemWe),
        .dmemAddr    (dmemAddr),
        .dmemWdata   (dmemWdata),
        .dmemAck     (dmemAck),
        .dmemRdata   (dmemRdata),
        .stallOut    (stallOut),
        .memWbOut    (memWbOut),
        .fwdRc       (fwdRc),
        .fwdRegWrite (fwdRegWrite),
        .waitCount   (waitCount),
        .memErr      (memErr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_ex(input logic [1:0] ot, input logic [3:0] oc,
                                          input logic [23:0] alu, input logic mw,
                                          input logic m2r, input logic rw,
                                          input logic [3:0] rc, input logic [23:0] rd3);
        logic [63:0] v;
        v = '0;
        v[63:62] = ot;
        v[61:58] = oc;
        v[57:34] = alu;
        v[33:31] = 3'b101;
        v[30]    = mw;
        v[29]    = m2r;
        v[28]    = rw;
        v[27:24] = rc;
        v[23:0]  = rd3;
        return v;
    endfunction

    function automatic logic [59:0] wb_of(input logic [63:0] e, input logic [23:0] rd);
        logic [59:0] w;
        w[59:58] = e[63:62];
        w[57:54] = e[61:58];
        w[53:30] = e[57:34];
        w[29:6]  = rd;
        w[5]     = e[29];
        w[4]     = e[28];
        w[3:0]   = e[27:24];
        return w;
    endfunction

    // Entered just after a rising edge; drives one cycle and scores it.
    task automatic cyc(input string tag, input logic [63:0] e, input logic ack,
                       input logic [23:0] rdata, input logic exp_req, input logic exp_stall,
                       input logic [59:0] exp_wb);
        logic [59:0] exp_q;
        exMemIn   = e;
        dmemAck   = ack;
        dmemRdata = rdata;
        #3;
        check({tag, ".req"}, dmemReq, exp_req);
        check({tag, ".stall"}, stallOut, exp_stall);
        check({tag, ".memErr"}, memErr, 1'b0);
        if (exp_req) begin
            check({tag, ".we"}, dmemWe, e[30]);
            check({tag, ".addr"}, dmemAddr, e[57:34]);
            check({tag, ".wdata"}, dmemWdata, e[23:0]);
        end
        if (dmemReq) req_cycles++;
        if (stallOut) stall_cycles++;
        sb_q.push_back(exp_wb);
        @(posedge clk);
        #1;
        exp_q = sb_q.pop_front();
        check({tag, ".memWb"}, memWbOut, exp_q);
    endtask

    logic [63:0] e_alu, e_st, e_ld, e_la, e_lb, e_lc;

    initial begin
        rst       = 1'b0;
        exMemIn   = '0;
        dmemAck   = 1'b0;
        dmemRdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.memWb", memWbOut, 60'd0);
        check("rst.req", dmemReq, 1'b0);
        check("rst.stall", stallOut, 1'b0);
        check("rst.waitCount", waitCount, 16'd0);
        check("rst.memErr", memErr, 1'b0);
        rst = 1'b1;

        // ALU op: single-cycle pass-through
        e_alu = mk_ex(2'd1, 4'd3, 24'h000007, 1'b0, 1'b0, 1'b1, 4'd5, 24'h000055);
        exMemIn = e_alu;
        #1;
        check("alu.fwdRw", fwdRegWrite, 1'b1);
        check("alu.fwdRc", fwdRc, 4'd5);
        cyc("alu", e_alu, 1'b0, 24'h0, 1'b0, 1'b0, wb_of(e_alu, 24'h0));

        // Store acked two cycles late
        e_st = mk_ex(2'd2, 4'd9, 24'h000010, 1'b1, 1'b0, 1'b0, 4'd0, 24'h00ABCD);
        req_cycles = 0;
        stall_cycles = 0;
        cyc("st0", e_st, 1'b0, 24'h0, 1'b1, 1'b1, 60'd0);
        cyc("st1", e_st, 1'b0, 24'h0, 1'b1, 1'b1, 60'd0);
        cyc("st2", e_st, 1'b1, 24'hFFFFFF, 1'b1, 1'b0, wb_of(e_st, 24'h0));
        check("st.reqCycles", req_cycles, 3);
        check("st.stallCycles", stall_cycles, 2);
        check("st.waitCount", waitCount, 16'd2);

        // Load with same-cycle ack
        e_ld = mk_ex(2'd3, 4'd1, 24'h000020, 1'b0, 1'b1, 1'b1, 4'd3, 24'h0);
        exMemIn = e_ld;
        dmemAck = 1'b0;
        #1;
        check("ld.fwdRwNoAck", fwdRegWrite, 1'b0);
        dmemAck = 1'b1;
        #1;
        check("ld.fwdRwAck", fwdRegWrite, 1'b1);
        stall_cycles = 0;
        cyc("ld", e_ld, 1'b1, 24'h123456, 1'b1, 1'b0, wb_of(e_ld, 24'h123456));
        check("ld.noStall", stall_cycles, 0);

        // Back-to-back loads, one wait cycle each
        e_la = mk_ex(2'd0, 4'd4, 24'h000100, 1'b0, 1'b1, 1'b1, 4'd7, 24'h0);
        e_lb = mk_ex(2'd1, 4'd5, 24'h000104, 1'b0, 1'b1, 1'b1, 4'd8, 24'h0);
        req_cycles = 0;
        stall_cycles = 0;
        cyc("la0", e_la, 1'b0, 24'h0, 1'b1, 1'b1, 60'd0);
        cyc("la1", e_la, 1'b1, 24'hA1A1A1, 1'b1, 1'b0, wb_of(e_la, 24'hA1A1A1));
        cyc("lb0", e_lb, 1'b0, 24'h0, 1'b1, 1'b1, 60'd0);
        cyc("lb1", e_lb, 1'b1, 24'hB2B2B2, 1'b1, 1'b0, wb_of(e_lb, 24'hB2B2B2));
        check("b2b.reqCycles", req_cycles, 4);
        check("b2b.stallCycles", stall_cycles, 2);
        check("b2b.waitCount", waitCount, 16'd4);

        // Reset asserted while BUSY
        e_lc = mk_ex(2'd2, 4'd6, 24'h000200, 1'b0, 1'b1, 1'b1, 4'd9, 24'h0);
        cyc("lc0", e_lc, 1'b0, 24'h0, 1'b1, 1'b1, 60'd0);
        cyc("lc1", e_lc, 1'b0, 24'h0, 1'b1, 1'b1, 60'd0);
        rst = 1'b0;
        #1;
        check("busyRst.req", dmemReq, 1'b0);
        check("busyRst.memWb", memWbOut, 60'd0);
        check("busyRst.stall", stallOut, 1'b0);
        check("busyRst.waitCount", waitCount, 16'd0);
        exMemIn = '0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("postRst", 64'd0, 1'b0, 24'h0, 1'b0, 1'b0, 60'd0);
        cyc("postRstLd", e_ld, 1'b1, 24'h654321, 1'b1, 1'b0, wb_of(e_ld, 24'h654321));

        check("sb.empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 24-bit pipeline; consumes the packed EX/MEM bundle and performs the data-memory load/store through a req/ack handshake with variable wait states.
- Stalls upstream stages while an access is outstanding and drives the packed MEM/WB register consumed by writeback.
- Exposes destination register, regWrite and ALU result to the hazard/forwarding logic.

Parameters:
- N, 24, datapath width
- BW, 16+2*N (64), EX/MEM bundle width
- WBW, 12+2*N (60), MEM/WB bundle width
- TIMEOUT, 255, wait-cycle limit (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- exMemIn  in  BW  EX/MEM bundle: opType[63:62] opCode[61:58] aluResult[57:34] zero[33] neg[32] branchFlag[31] memWrite[30] memToReg[29] regWrite[28] Rc[27:24] rd3[23:0]
- dmemReq  out  1  access request
- dmemWe  out  1  1=store, 0=load
- dmemAddr  out  N  address = aluResult
- dmemWdata  out  N  store data = rd3
- dmemAck  in  1  access complete; load data valid same cycle
- dmemRdata  in  N  load data
- stallOut  out  1  holds EX/MEM and earlier stages (drives their en low)
- memWbOut  out  WBW  {opType[59:58], opCode[57:54], aluResult[53:30], readData[29:6], memToReg[5], regWrite[4], Rc[3:0]}
- fwdRc  out  4  Rc of instruction currently in MEM
- fwdRegWrite  out  1  regWrite of instruction in MEM (0 for loads until ack)
- waitCount  out  16  saturating count of stall cycles since reset
- memErr  out  1  one-cycle timeout pulse (0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset (rst=0, async): state IDLE; memWbOut=0; dmemReq/dmemWe=0; stallOut=0; waitCount=0; memErr=0. Outstanding access is abandoned immediately; dmemReq drops in the same cycle.
- memOp = memWrite | memToReg. When both are set, the access is a store; readData=0.
- Non-memory op: memWbOut captures the bundle on the next edge with readData=0. Latency 1, no stall.
- Memory op, IDLE state:
  - dmemReq=1 combinationally in the same cycle; addr/wdata/we driven from exMemIn.
  - If dmemAck=1 that cycle: no stall, memWbOut captures on the next edge with readData=dmemRdata.
  - Else: stallOut=1, go to BUSY.
- BUSY state:
  - dmemReq and all request fields are held stable (exMemIn is frozen upstream); stallOut=1.
  - Each non-ack cycle memWbOut loads a bubble (regWrite=0, memToReg=0, remaining fields 0) and waitCount increments, saturating at 0xFFFF.
  - On dmemAck: stallOut=0, memWbOut captures the completed instruction, return to IDLE.
- Exactly one request per instruction: after ack, upstream advances, so the next cycle presents a new bundle.
- Back-to-back memory ops: a second op is issued in the IDLE cycle immediately following the ack. No dead cycle.
- Forwarding: fwdRegWrite = regWrite & ~memToReg, or regWrite & dmemAck for loads.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Counter per access; in BUSY, after TIMEOUT cycles without ack, drop dmemReq and complete the instruction with readData=0 and regWrite forced 0.
  - memErr=1 for that one cycle; return to IDLE.
- MEM_TIMEOUT_EN undefined: waits indefinitely; memErr tied 0; no counter logic.

Decomposition:
- Package mem_pkg: N, BW, WBW, bit offsets of every EX/MEM and MEM/WB field, state enum {IDLE, BUSY}, bubble constant.
- Sub-module dmem_port_ctrl: FSM, handshake, stall, timeout counter. mem_stage holds field unpacking, the MEM/WB register, waitCount and forwarding outputs.

Test Plan:
- ALU op regWrite=1, Rc=5, aluResult=0x000007 -> next cycle memWbOut regWrite=1, Rc=5, aluResult=0x7, readData=0; stallOut never high.
- Store, aluResult=0x000010, rd3=0x00ABCD, ack 2 cycles late -> dmemReq/dmemWe high 3 cycles with addr 0x10, wdata 0xABCD; stallOut high 2 cycles; two bubbles; waitCount=2.
- Load, ack same cycle, rdata=0x123456, Rc=3 -> no stall; next cycle readData=0x123456, memToReg=1, regWrite=1.
- Two consecutive loads, each acked after 1 wait cycle -> exactly 2 requests, 2 stall cycles total, results in program order.
- rst pulled low in BUSY -> dmemReq=0 and memWbOut=0 immediately; after release, IDLE with no re-request until a new bundle arrives.
- MEM_TIMEOUT_EN, TIMEOUT=4, no ack -> request dropped after 4 wait cycles; memErr pulses once; memWbOut regWrite=0, readData=0.
